// File: rtl/sw_bank_pkg.sv
// Shared sizing and payload types for the packet-buffer bank controller.
package sw_bank_pkg;

    localparam int unsigned NP         = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned DEPTH      = 4608;
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam int unsigned PW         = (NP > 1) ? $clog2(NP) : 1;

    typedef logic [PW-1:0]         port_idx_t;
    typedef logic [AW-1:0]         addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // Registered drive for the SRAM write port
    typedef struct packed {
        logic  we;
        addr_t addr;
        data_t data;
    } sram_wr_t;

    // Registered drive for the SRAM read port
    typedef struct packed {
        logic  re;
        addr_t addr;
    } sram_rd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;
    int unsigned   idx;

    // Search upward from the pointer with wrap; first requester wins
    always_comb begin
        o_gnt   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && i_req[PW'(idx)]) begin
                found            = 1'b1;
                o_gnt[PW'(idx)]  = 1'b1;
                ptr_nxt          = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/sram_bank_ctrl.sv
// Arbitrates NP writers and NP readers onto one simple-dual-port SRAM bank,
// with read-after-write forwarding on a same-cycle address collision.
module sram_bank_ctrl
    import sw_bank_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NP-1:0]            i_wr_req,
    input  logic [NP*AW-1:0]         i_wr_addr,
    input  logic [NP*DATA_WIDTH-1:0] i_wr_data,
    output logic [NP-1:0]            o_wr_gnt,
    input  logic [NP-1:0]            i_rd_req,
    input  logic [NP*AW-1:0]         i_rd_addr,
    output logic [NP-1:0]            o_rd_gnt,
    output logic [NP-1:0]            o_rd_valid,
    output logic [DATA_WIDTH-1:0]    o_rd_data,
    output logic                     o_sram_write,
    output logic [AW-1:0]            o_sram_addr_wr,
    output logic [DATA_WIDTH-1:0]    o_sram_data,
    output logic                     o_sram_read,
    output logic [AW-1:0]            o_sram_addr_r,
    input  logic [DATA_WIDTH-1:0]    i_sram_data
);

    logic [NP-1:0] wr_gnt;
    logic [NP-1:0] rd_gnt;
    addr_t         wr_addr_sel;
    data_t         wr_data_sel;
    addr_t         rd_addr_sel;

    sram_wr_t      wr_q;
    sram_rd_t      rd_q;
    logic [NP-1:0] rd_tag;
    logic [NP-1:0] rd_valid_q;
    logic          byp_hit;
    data_t         byp_data;

    rr_arbiter #(.N(NP)) u_wr_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_wr_req),
        .o_gnt   (wr_gnt)
    );

    rr_arbiter #(.N(NP)) u_rd_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_rd_req),
        .o_gnt   (rd_gnt)
    );

    // One-hot grant selects the winning port's address/data
    always_comb begin
        wr_addr_sel = '0;
        wr_data_sel = '0;
        rd_addr_sel = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            if (wr_gnt[k]) begin
                wr_addr_sel = i_wr_addr[k*AW +: AW];
                wr_data_sel = i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_gnt[k]) begin
                rd_addr_sel = i_rd_addr[k*AW +: AW];
            end
        end
    end

    // SRAM drive, read-tag pipe and bypass capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            rd_tag     <= '0;
            rd_valid_q <= '0;
            byp_hit    <= 1'b0;
            byp_data   <= '0;
        end else begin
            wr_q.we <= |wr_gnt;
            if (|wr_gnt) begin
                wr_q.addr <= wr_addr_sel;
                wr_q.data <= wr_data_sel;
            end
            rd_q.re <= |rd_gnt;
            if (|rd_gnt) begin
                rd_q.addr <= rd_addr_sel;
            end
            rd_tag     <= rd_gnt;
            rd_valid_q <= rd_tag;
            // SRAM returns pre-write contents on a collision, so forward the write word
            byp_hit    <= wr_q.we && rd_q.re && (wr_q.addr == rd_q.addr);
            byp_data   <= wr_q.data;
        end
    end

    assign o_wr_gnt       = wr_gnt;
    assign o_rd_gnt       = rd_gnt;
    assign o_sram_write   = wr_q.we;
    assign o_sram_addr_wr = wr_q.addr;
    assign o_sram_data    = wr_q.data;
    assign o_sram_read    = rd_q.re;
    assign o_sram_addr_r  = rd_q.addr;
    assign o_rd_valid     = rd_valid_q;
    assign o_rd_data      = byp_hit ? byp_data : i_sram_data;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl with a behavioural read-before-write SRAM beside it.
module tb_sram_bank_ctrl;
    import sw_bank_pkg::*;

    localparam int unsigned DW = DATA_WIDTH;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic [NP-1:0]       i_wr_req;
    logic [NP*AW-1:0]    i_wr_addr;
    logic [NP*DW-1:0]    i_wr_data;
    logic [NP-1:0]       o_wr_gnt;
    logic [NP-1:0]       i_rd_req;
    logic [NP*AW-1:0]    i_rd_addr;
    logic [NP-1:0]       o_rd_gnt;
    logic [NP-1:0]       o_rd_valid;
    logic [DW-1:0]       o_rd_data;
    logic                o_sram_write;
    logic [AW-1:0]       o_sram_addr_wr;
    logic [DW-1:0]       o_sram_data;
    logic                o_sram_read;
    logic [AW-1:0]       o_sram_addr_r;
    logic [DW-1:0]       sram_q;

    logic [DW-1:0]       mem [0:DEPTH-1];

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    sram_bank_ctrl dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_wr_req       (i_wr_req),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .o_wr_gnt       (o_wr_gnt),
        .i_rd_req       (i_rd_req),
        .i_rd_addr      (i_rd_addr),
        .o_rd_gnt       (o_rd_gnt),
        .o_rd_valid     (o_rd_valid),
        .o_rd_data      (o_rd_data),
        .o_sram_write   (o_sram_write),
        .o_sram_addr_wr (o_sram_addr_wr),
        .o_sram_data    (o_sram_data),
        .o_sram_read    (o_sram_read),
        .o_sram_addr_r  (o_sram_addr_r),
        .i_sram_data    (sram_q)
    );

    // Synchronous SRAM: a same-cycle read sees the old word
    always @(posedge i_clk) begin
        if (o_sram_read)  sram_q <= mem[o_sram_addr_r];
        if (o_sram_write) mem[o_sram_addr_wr] <= o_sram_data;
    end

    typedef struct {
        logic [NP-1:0] wr_req;
        logic [NP-1:0] rd_req;
        logic [NP-1:0] ewg;
        logic [NP-1:0] erg;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    function automatic int oh2i(input logic [NP-1:0] v);
        int r = 0;
        for (int k = 0; k < int'(NP); k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic do_write(input int p, input int a, input logic [DW-1:0] d);
        int c = 0;
        edge1();
        i_wr_addr[p*AW +: AW] = AW'(a);
        i_wr_data[p*DW +: DW] = d;
        i_wr_req[p]           = 1'b1;
        mid();
        while (!o_wr_gnt[p] && c < 8) begin
            edge1(); mid(); c++;
        end
        chk("wr_gnt_wait", 64'(o_wr_gnt[p]), 64'(1));
        edge1();
        i_wr_req[p] = 1'b0;
        mid();
        chk("wr_sram_we",   64'(o_sram_write),   64'(1));
        chk("wr_sram_addr", 64'(o_sram_addr_wr), 64'(a));
        chk("wr_sram_data", 64'(o_sram_data),    64'(d));
    endtask

    task automatic do_read(input int p, input int a, input logic [DW-1:0] exp);
        int c = 0;
        edge1();
        i_rd_addr[p*AW +: AW] = AW'(a);
        i_rd_req[p]           = 1'b1;
        mid();
        while (!o_rd_gnt[p] && c < 8) begin
            edge1(); mid(); c++;
        end
        chk("rd_gnt_wait", 64'(o_rd_gnt[p]), 64'(1));
        edge1();
        i_rd_req[p] = 1'b0;
        mid();
        chk("rd_sram_re",    64'(o_sram_read),   64'(1));
        chk("rd_sram_addr",  64'(o_sram_addr_r), 64'(a));
        chk("rd_valid_t1",   64'(o_rd_valid),    64'(0));
        edge1(); mid();
        chk("rd_valid_t2",   64'(o_rd_valid),    64'(1 << p));
        chk("rd_data_t2",    64'(o_rd_data),     64'(exp));
        edge1(); mid();
        chk("rd_valid_t3",   64'(o_rd_valid),    64'(0));
    endtask

    // Write and read granted in the same cycle (both sole requesters)
    task automatic do_both(input int wp, input int wa, input logic [DW-1:0] wd,
                           input int rp, input int ra, input logic [DW-1:0] exp);
        edge1();
        i_wr_addr[wp*AW +: AW] = AW'(wa);
        i_wr_data[wp*DW +: DW] = wd;
        i_rd_addr[rp*AW +: AW] = AW'(ra);
        i_wr_req[wp] = 1'b1;
        i_rd_req[rp] = 1'b1;
        mid();
        chk("both_wr_gnt", 64'(o_wr_gnt), 64'(1 << wp));
        chk("both_rd_gnt", 64'(o_rd_gnt), 64'(1 << rp));
        edge1();
        i_wr_req[wp] = 1'b0;
        i_rd_req[rp] = 1'b0;
        mid();
        chk("both_we", 64'(o_sram_write), 64'(1));
        chk("both_re", 64'(o_sram_read),  64'(1));
        edge1(); mid();
        chk("both_rd_valid", 64'(o_rd_valid), 64'(1 << rp));
        chk("both_rd_data",  64'(o_rd_data),  64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0010, 4'b0001, 4'b0010};
        tbl[1]  = '{4'b1111, 4'b0011, 4'b0010, 4'b0001};
        tbl[2]  = '{4'b1111, 4'b0011, 4'b0100, 4'b0010};
        tbl[3]  = '{4'b1111, 4'b0011, 4'b1000, 4'b0001};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
        tbl[5]  = '{4'b1111, 4'b1000, 4'b0010, 4'b1000};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0000};
        tbl[7]  = '{4'b1111, 4'b0100, 4'b1000, 4'b0100};
        tbl[8]  = '{4'b0000, 4'b1001, 4'b0000, 4'b1000};
        tbl[9]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
        tbl[10] = '{4'b0011, 4'b1111, 4'b0001, 4'b0001};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};

        // Reset held with every request asserted
        i_rst_n   = 1'b0;
        i_wr_req  = '1;
        i_rd_req  = '1;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_rd_addr = '0;
        for (int k = 0; k < int'(NP); k++) begin
            i_wr_addr[k*AW +: AW] = AW'(200 + k);
            i_wr_data[k*DW +: DW] = DW'(32'hC0DE_0000 + k);
            i_rd_addr[k*AW +: AW] = AW'(300 + k);
        end
        repeat (3) edge1();
        mid();
        chk("rst_sram_we",   64'(o_sram_write),   64'(0));
        chk("rst_sram_awr",  64'(o_sram_addr_wr), 64'(0));
        chk("rst_sram_data", 64'(o_sram_data),    64'(0));
        chk("rst_sram_re",   64'(o_sram_read),    64'(0));
        chk("rst_sram_ar",   64'(o_sram_addr_r),  64'(0));
        chk("rst_rd_valid",  64'(o_rd_valid),     64'(0));
        edge1();
        i_rst_n = 1'b1;
        mid();
        chk("rst_rel_wr_gnt", 64'(o_wr_gnt), 64'(4'b0001));
        chk("rst_rel_rd_gnt", 64'(o_rd_gnt), 64'(4'b0001));
        edge1();
        i_wr_req = '0;
        i_rd_req = '0;
        i_rst_n  = 1'b0;
        edge1();
        i_rst_n  = 1'b1;
        edge1();

        // Table: arbitration plus pipelined SRAM drive and read-valid timing
        for (int i = 0; i < 12; i++) begin
            edge1();
            i_wr_req = tbl[i].wr_req;
            i_rd_req = tbl[i].rd_req;
            mid();
            chk($sformatf("v%0d_wr_gnt", i), 64'(o_wr_gnt), 64'(tbl[i].ewg));
            chk($sformatf("v%0d_rd_gnt", i), 64'(o_rd_gnt), 64'(tbl[i].erg));
            if (i >= 1) begin
                chk($sformatf("v%0d_we", i), 64'(o_sram_write), 64'(|tbl[i-1].ewg));
                if (|tbl[i-1].ewg) begin
                    chk($sformatf("v%0d_awr", i), 64'(o_sram_addr_wr),
                        64'(200 + oh2i(tbl[i-1].ewg)));
                    chk($sformatf("v%0d_wdata", i), 64'(o_sram_data),
                        64'(32'hC0DE_0000 + oh2i(tbl[i-1].ewg)));
                end
                chk($sformatf("v%0d_re", i), 64'(o_sram_read), 64'(|tbl[i-1].erg));
                if (|tbl[i-1].erg)
                    chk($sformatf("v%0d_ar", i), 64'(o_sram_addr_r),
                        64'(300 + oh2i(tbl[i-1].erg)));
            end
            if (i >= 2)
                chk($sformatf("v%0d_rd_valid", i), 64'(o_rd_valid), 64'(tbl[i-2].erg));
        end
        repeat (3) edge1();

        // Read latency after a write
        do_write(2, 100, 32'hDEAD_BEEF);
        repeat (2) edge1();
        do_read(1, 100, 32'hDEAD_BEEF);

        // Collision bypass, non-colliding read, then memory really updated
        do_write(0, 7, 32'h0000_0001);
        do_write(1, 8, 32'h8888_0008);
        do_both(0, 7, 32'hA5A5_A5A5, 3, 7, 32'hA5A5_A5A5);
        do_both(0, 7, 32'h5A5A_5A5A, 3, 8, 32'h8888_0008);
        do_read(2, 7, 32'h5A5A_5A5A);

        // Reset while a read is in flight
        edge1();
        i_rd_addr[0*AW +: AW] = AW'(7);
        i_rd_req[0] = 1'b1;
        mid();
        chk("mr_rd_gnt", 64'(o_rd_gnt[0]), 64'(1));
        edge1();
        i_rd_req[0] = 1'b0;
        i_rst_n     = 1'b0;
        mid();
        chk("mr_sram_re", 64'(o_sram_read), 64'(0));
        chk("mr_valid_rst", 64'(o_rd_valid), 64'(0));
        edge1();
        i_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mid();
            chk($sformatf("mr_valid_c%0d", c), 64'(o_rd_valid), 64'(0));
            edge1();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
